ram_burst_master: RTL and testbench
===================================

# ram_burst_master

Initiator side of the SPRAM word-memory port. Turns one command (byte start address, word count, direction) into a burst of single-word writes or reads on the memory port. Bursts are bounded by the 128 KB SPRAM range. On the other side it exchanges pixel words with image-processing cores over valid/ready streams. It sits between the processing pipeline and the RAM responder and is the only block driving the memory port.

## Interface
- `MEM_BYTES`, 131072, memory size in bytes; power of two; addresses wrap modulo this value.
- `LEN_W`, 16, width of the word-count field.

- `clk` in 1: single clock for the whole block.
- `reset_n` in 1: synchronous, active-low reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: command accepted when high together with `cmd_valid`.
- `cmd_write` in 1: 1 = write burst, 0 = read burst.
- `cmd_addr` in 32: byte start address; bit 0 ignored.
- `cmd_len` in LEN_W: burst length in 16-bit words; 0 = empty burst.
- `wr_data` in 16: write stream data.
- `wr_valid` in 1: write stream valid.
- `wr_ready` out 1: write stream ready.
- `rd_data` out 16: read stream data.
- `rd_valid` out 1: read stream valid.
- `rd_ready` in 1: read stream ready.
- `done` out 1: one-cycle pulse when a burst completes.
- `mem_addr` out 32: byte address to memory.
- `mem_wr_en` out 1: single-cycle write strobe.
- `mem_rd_en` out 1: single-cycle read strobe.
- `mem_data_write` out 16: write data.
- `mem_data_read` in 16: read data, meaningful only while `mem_data_read_valid` is high.
- `mem_data_read_valid` in 1: read data valid, one cycle after the `mem_rd_en` cycle.

## Operation
- States: IDLE, WRITE, RD_ISSUE, RD_WAIT, FINISH.
- IDLE:
  - `cmd_ready` = 1.
  - On handshake, latch `addr = {cmd_addr[log2(MEM_BYTES)-1:1], 0}` and `remaining = cmd_len`.
  - `cmd_len` = 0 -> go to FINISH.
  - Otherwise, `cmd_write` = 1 -> WRITE; `cmd_write` = 0 -> RD_ISSUE.
- WRITE:
  - `wr_ready` = 1.
  - Each `wr_valid`&&`wr_ready` registers `mem_addr` = addr, `mem_data_write` = `wr_data`, and `mem_wr_en` = 1 for exactly the next cycle.
  - Then addr += 2 and remaining -= 1.
  - The last word moves to FINISH, and `wr_ready` drops in that same cycle.
- RD_ISSUE:
  - Requires the output register to be empty, or being drained this cycle.
  - Then registers `mem_addr` = addr and `mem_rd_en` = 1 for one cycle, and goes to RD_WAIT.
- RD_WAIT:
  - `mem_rd_en` = 0.
  - On `mem_data_read_valid`, load `rd_data` and set `rd_valid`; then addr += 2 and remaining -= 1.
  - remaining = 0 -> FINISH; otherwise -> RD_ISSUE.
- FINISH:
  - `done` = 1 for one cycle, then IDLE.
  - For reads, FINISH waits until the last word has been taken (`rd_valid`&&`rd_ready`).
- Memory contract:
  - `mem_rd_en` is never high two consecutive cycles.
  - `mem_wr_en` and `mem_rd_en` are never high together.
  - `mem_addr` is held stable while `mem_rd_en` is high.
- Address arithmetic:
  - Modulo MEM_BYTES; 0x1FFFE + 2 -> 0x00000.
  - `mem_addr[31:log2(MEM_BYTES)]` and `mem_addr[0]` are always 0.
- Output register: `rd_valid` stays high with `rd_data` stable until `rd_ready`.
- `mem_data_read_valid` outside RD_WAIT is ignored.

## Timing
- Reset values:
  - `cmd_ready` = 1 (IDLE).
  - `wr_ready`, `rd_valid`, `done`, `mem_wr_en`, `mem_rd_en` = 0.
  - `rd_data`, `mem_addr`, `mem_data_write` = 0.
- Reset mid-burst: the burst is abandoned, no `done`, all outputs go to their reset values in the next cycle, and a pending read return is dropped.
- Write latency: `wr` handshake at cycle N -> `mem_wr_en` at N+1.
  - Full rate, 1 word/cycle.
  - An n-word burst with continuous `wr_valid` asserts `done` at cycle N+n.
- Read latency:
  - `mem_rd_en` at N -> `mem_data_read_valid` at N+1 -> `rd_valid` at N+2.
  - With `rd_ready` held high, one word every 3 cycles.
- `done` asserts one cycle after the final write handshake, or one cycle after the final `rd_valid`&&`rd_ready`.
- `cmd_ready` is low from the cycle after acceptance until the cycle after `done`.

## Structure
- Shared package `ram_pkg`:
  - state encoding.
  - `MEM_BYTES`.
  - `WORD_W` = 16.
  - address-bit constants (bank bits [16:15], word bits [14:1]), shared with the RAM responder.
- One natural sub-module, `ram_addr_gen`: loadable address and remaining-count generator with modulo wrap and `last` flag.

## Test plan
- Write addr 0x00100, len 4, data 0xA001..0xA004 held valid -> `mem_wr_en` for 4 consecutive cycles at 0x100/0x102/0x104/0x106; `done` 1 cycle after the 4th handshake.
- Read back 0x00100, len 4, `rd_ready` = 1, against a memory model -> `rd_data` 0xA001..0xA004 in order, `mem_rd_en` never on back-to-back cycles, `done` once.
- Read len 3 with `rd_ready` low 10 cycles after the first word -> `rd_data` held, no second `mem_rd_en` until the drain; all 3 words delivered.
- Write addr 0x1FFFC, len 4 -> addresses 0x1FFFC, 0x1FFFE, 0x00000, 0x00002; `mem_addr[31:17]` = 0.
- `cmd_len` = 0 (either direction) -> no memory strobes, `done` at the cycle after acceptance, `cmd_ready` back the next cycle.
- `reset_n` low during RD_WAIT of word 2 of 5 -> next cycle all outputs at reset values, late `mem_data_read_valid` ignored, no `done`; a new write command after reset completes normally.

Source files
------------

// File: rtl/ram_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ram_pkg                                                       |
// | Purpose  : Shared definitions for the SPRAM initiator and responder:     |
// |            memory size, word width, address-bit fields and the burst     |
// |            master state encoding.                                        |
// | Ports    : none (package)                                                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package ram_pkg;

  // Total SPRAM size in bytes; addresses wrap modulo this value.
  localparam int MEM_BYTES = 131072;

  // Width of one memory word.
  localparam int WORD_W = 16;

  // Byte-address field layout shared with the RAM responder.
  localparam int c_bank_msb = 16;
  localparam int c_bank_lsb = 15;
  localparam int c_word_msb = 14;
  localparam int c_word_lsb = 1;

  // Burst master states.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WRITE    = 3'd1,
    ST_RD_ISSUE = 3'd2,
    ST_RD_WAIT  = 3'd3,
    ST_FINISH   = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/ram_addr_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ram_addr_gen                                                  |
// | Purpose  : Loadable word-address and remaining-count generator for one  |
// |            burst. The address advances one word per step and wraps      |
// |            modulo MEM_BYTES; 'last' flags the final word of the burst.  |
// | Ports    : clk, reset_n   - clock, synchronous active-low reset         |
// |            load          - capture load_word / load_len                 |
// |            load_word     - start address as a word index                |
// |            load_len      - burst length in words                        |
// |            step          - advance address, consume one word            |
// |            addr          - current even byte address                    |
// |            last          - exactly one word remains                     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module ram_addr_gen #(
  parameter int MEM_BYTES = 131072,
  parameter int LEN_W     = 16
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           load,
  input  logic [$clog2(MEM_BYTES)-2:0]   load_word,
  input  logic [LEN_W-1:0]               load_len,
  input  logic                           step,
  output logic [$clog2(MEM_BYTES)-1:0]   addr,
  output logic                           last
);

  localparam int c_aw = $clog2(MEM_BYTES);

  // Holding a word index rather than a byte address keeps bit 0 at zero by
  // construction and makes the modulo wrap a plain binary overflow.
  logic [c_aw-2:0]  r_word;
  logic [LEN_W-1:0] r_remaining;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_word      <= '0;
      r_remaining <= '0;
    end else if (load) begin
      r_word      <= load_word;
      r_remaining <= load_len;
    end else if (step) begin
      r_word      <= r_word + (c_aw-1)'(1);
      r_remaining <= r_remaining - LEN_W'(1);
    end
  end

  assign addr = {r_word, 1'b0};
  assign last = (r_remaining == LEN_W'(1));

endmodule
`default_nettype wire

// File: rtl/ram_burst_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ram_burst_master                                              |
// | Purpose  : Initiator on the SPRAM word port. Converts one command (byte  |
// |            start address, word count, direction) into a burst of        |
// |            single-word writes or reads, exchanging data with the        |
// |            processing pipeline over valid/ready streams.                |
// | Ports    : clk, reset_n                    - clock, sync active-low rst |
// |            cmd_valid/ready/write/addr/len  - burst command              |
// |            wr_data/valid/ready             - write data stream (in)     |
// |            rd_data/valid/ready             - read data stream (out)     |
// |            done                            - burst complete pulse       |
// |            mem_addr/wr_en/rd_en/data_write - memory request side        |
// |            mem_data_read/_valid            - memory read return         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module ram_burst_master #(
  parameter int MEM_BYTES = ram_pkg::MEM_BYTES,
  parameter int LEN_W     = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [31:0]      cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [15:0]      wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [15:0]      rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic             done,
  output logic [31:0]      mem_addr,
  output logic             mem_wr_en,
  output logic             mem_rd_en,
  output logic [15:0]      mem_data_write,
  input  logic [15:0]      mem_data_read,
  input  logic             mem_data_read_valid
);

  import ram_pkg::*;

  localparam int c_aw = $clog2(MEM_BYTES);

  state_t            r_state;
  state_t            w_next;

  logic              w_load;
  logic              w_step;
  logic              w_wr_fire;
  logic              w_rd_issue;
  logic              w_rd_load;
  logic              w_last;
  logic [c_aw-1:0]   w_addr;

  logic [c_aw-1:0]   r_mem_addr;
  logic              r_mem_wr_en;
  logic              r_mem_rd_en;
  logic [WORD_W-1:0] r_mem_data_write;
  logic [WORD_W-1:0] r_rd_data;
  logic              r_rd_valid;

  // Address bits above the memory range and the byte-select bit are
  // architecturally ignored.
  logic              w_unused_addr_bits;
  assign w_unused_addr_bits = ^{cmd_addr[31:c_aw], cmd_addr[0]};

  ram_addr_gen #(
    .MEM_BYTES (MEM_BYTES),
    .LEN_W     (LEN_W)
  ) u_addr_gen (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (w_load),
    .load_word (cmd_addr[c_aw-1:1]),
    .load_len  (cmd_len),
    .step      (w_step),
    .addr      (w_addr),
    .last      (w_last)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    cmd_ready  = 1'b0;
    wr_ready   = 1'b0;
    done       = 1'b0;
    w_load     = 1'b0;
    w_step     = 1'b0;
    w_wr_fire  = 1'b0;
    w_rd_issue = 1'b0;
    w_rd_load  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          w_load = 1'b1;
          if (cmd_len == '0) begin
            w_next = ST_FINISH;
          end else if (cmd_write) begin
            w_next = ST_WRITE;
          end else begin
            w_next = ST_RD_ISSUE;
          end
        end
      end

      ST_WRITE: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          w_wr_fire = 1'b1;
          w_step    = 1'b1;
          if (w_last) begin
            w_next = ST_FINISH;
          end
        end
      end

      ST_RD_ISSUE: begin
        // Only one word may be in flight: the returning word needs a free
        // output register when it lands two cycles later.
        if (!r_rd_valid || rd_ready) begin
          w_rd_issue = 1'b1;
          w_next     = ST_RD_WAIT;
        end
      end

      ST_RD_WAIT: begin
        // The return cannot legally coincide with the strobe cycle itself;
        // ignoring it there also keeps read strobes at least two cycles apart.
        if (mem_data_read_valid && !r_mem_rd_en) begin
          w_rd_load = 1'b1;
          w_step    = 1'b1;
          w_next    = w_last ? ST_FINISH : ST_RD_ISSUE;
        end
      end

      ST_FINISH: begin
        // For reads, completion is reported only once the last word is taken.
        if (!r_rd_valid) begin
          done   = 1'b1;
          w_next = ST_IDLE;
        end
      end

      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_mem_addr       <= '0;
      r_mem_wr_en      <= 1'b0;
      r_mem_rd_en      <= 1'b0;
      r_mem_data_write <= '0;
      r_rd_data        <= '0;
      r_rd_valid       <= 1'b0;
    end else begin
      r_mem_wr_en <= w_wr_fire;
      r_mem_rd_en <= w_rd_issue;

      if (w_wr_fire) begin
        r_mem_addr       <= w_addr;
        r_mem_data_write <= wr_data;
      end else if (w_rd_issue) begin
        r_mem_addr <= w_addr;
      end

      if (w_rd_load) begin
        r_rd_data  <= mem_data_read;
        r_rd_valid <= 1'b1;
      end else if (rd_ready) begin
        r_rd_valid <= 1'b0;
      end
    end
  end

  assign mem_addr       = {{(32-c_aw){1'b0}}, r_mem_addr};
  assign mem_wr_en      = r_mem_wr_en;
  assign mem_rd_en      = r_mem_rd_en;
  assign mem_data_write = r_mem_data_write;
  assign rd_data        = r_rd_data;
  assign rd_valid       = r_rd_valid;

endmodule
`default_nettype wire

// File: tb/tb_ram_burst_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_ram_burst_master                                           |
// | Purpose  : Self-checking bench for ram_burst_master with a word-memory  |
// |            responder and a reference image of memory contents.          |
// | Ports    : none                                                          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_ram_burst_master;

  localparam int MB = 131072;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [15:0] cmd_len = '0;
  logic [15:0] wr_data = '0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        rd_ready = 1'b0;
  logic        done;
  logic [31:0] mem_addr;
  logic        mem_wr_en;
  logic        mem_rd_en;
  logic [15:0] mem_data_write;
  logic [15:0] mem_data_read = '0;
  logic        mem_data_read_valid = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram_burst_master #(
    .MEM_BYTES (MB),
    .LEN_W     (16)
  ) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .cmd_valid           (cmd_valid),
    .cmd_ready           (cmd_ready),
    .cmd_write           (cmd_write),
    .cmd_addr            (cmd_addr),
    .cmd_len             (cmd_len),
    .wr_data             (wr_data),
    .wr_valid            (wr_valid),
    .wr_ready            (wr_ready),
    .rd_data             (rd_data),
    .rd_valid            (rd_valid),
    .rd_ready            (rd_ready),
    .done                (done),
    .mem_addr            (mem_addr),
    .mem_wr_en           (mem_wr_en),
    .mem_rd_en           (mem_rd_en),
    .mem_data_write      (mem_data_write),
    .mem_data_read       (mem_data_read),
    .mem_data_read_valid (mem_data_read_valid)
  );

  // Memory responder: data returns one cycle after the read strobe; junk
  // is presented on the data bus whenever it is not valid.
  logic [15:0] ram [65536];
  always @(posedge clk) begin
    mem_data_read_valid <= mem_rd_en;
    if (mem_rd_en) mem_data_read <= ram[mem_addr[16:1]];
    else           mem_data_read <= 16'($urandom);
    if (mem_wr_en) ram[mem_addr[16:1]] <= mem_data_write;
  end

  // Reference image of what memory should hold, kept from command semantics.
  logic [15:0] ref_mem [65536];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Byte address of word i of a burst starting at a.
  function automatic int burst_addr(input logic [31:0] a, input int i);
    int base;
    base = int'(a % 32'(MB));
    base = base - (base % 2);
    return (base + 2 * i) % MB;
  endfunction

  // Observation logs filled by the monitor.
  bit          mon_en = 1'b1;
  int          done_cnt = 0;
  logic [31:0] wr_addr_q[$];
  logic [15:0] wr_data_q[$];
  int          wr_cyc_q[$];
  logic [15:0] rd_q[$];
  int          rd_cyc_q[$];
  int          rden_cyc_q[$];

  initial begin : monitor
    logic        prev_rd_en;
    logic        prev_hold;
    logic [15:0] prev_rd_data;
    prev_rd_en = 1'b0;
    prev_hold = 1'b0;
    prev_rd_data = '0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (mem_rd_en) begin
          check("rd_en_back_to_back", 32'(prev_rd_en), 32'd0);
          check("wr_rd_overlap", 32'(mem_wr_en), 32'd0);
          rden_cyc_q.push_back(cyc);
        end
        if (mem_wr_en || mem_rd_en)
          check("mem_addr_range", 32'({mem_addr[31:17], mem_addr[0]}), 32'd0);
        if (prev_hold) begin
          check("rd_hold_valid", 32'(rd_valid), 32'd1);
          check("rd_hold_data", 32'(rd_data), 32'(prev_rd_data));
        end
        if (mem_wr_en) begin
          wr_addr_q.push_back(mem_addr);
          wr_data_q.push_back(mem_data_write);
          wr_cyc_q.push_back(cyc);
        end
        if (rd_valid && rd_ready) begin
          rd_q.push_back(rd_data);
          rd_cyc_q.push_back(cyc);
        end
        if (done) done_cnt++;
      end
      prev_rd_en = mem_rd_en;
      prev_hold = rd_valid && !rd_ready;
      prev_rd_data = rd_data;
    end
  end

  task automatic send_cmd(input logic wr, input logic [31:0] a, input int len, output int acc);
    cmd_write = wr;
    cmd_addr = a;
    cmd_len = 16'(len);
    cmd_valid = 1'b1;
    acc = -1;
    for (int k = 0; k < 20 && acc < 0; k++) begin
      @(negedge clk);
      if (cmd_ready) acc = cyc;
      else tick();
    end
    check("cmd_accepted", 32'(acc >= 0), 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(output int done_c);
    done_c = -1;
    for (int k = 0; k < 400 && done_c < 0; k++) begin
      if (k > 0) begin
        tick();
        @(negedge clk);
      end
      if (done) done_c = cyc;
    end
    check("done_seen", 32'(done_c >= 0), 32'd1);
    check("cmd_ready_low_at_done", 32'(cmd_ready), 32'd0);
    tick();
    @(negedge clk);
    check("cmd_ready_after_done", 32'(cmd_ready), 32'd1);
    check("done_single_pulse", 32'(done), 32'd0);
    tick();
  endtask

  task automatic run_write(input logic [31:0] a, input int len, input bit gaps, input bit fixed);
    logic [15:0] d[$];
    int acc, first_hs, last_hs, done_c, d0;
    for (int i = 0; i < len; i++)
      d.push_back(fixed ? 16'hA001 + 16'(i) : 16'($urandom));
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
    d0 = done_cnt;
    first_hs = -1;
    last_hs = -1;
    send_cmd(1'b1, a, len, acc);
    for (int i = 0; i < len; i++) begin
      if (gaps) begin
        while ($urandom_range(0, 2) == 0) begin
          wr_valid = 1'b0;
          tick();
        end
      end
      wr_valid = 1'b1;
      wr_data = d[i];
      @(negedge clk);
      check("wr_ready", 32'(wr_ready), 32'd1);
      if (i == 0) first_hs = cyc;
      last_hs = cyc;
      tick();
    end
    wr_valid = 1'b0;
    wr_data = 16'($urandom);
    @(negedge clk);
    check("wr_ready_drop", 32'(wr_ready), 32'd0);
    wait_done(done_c);
    check("wr_done_cycle", done_c, last_hs + 1);
    check("wr_done_count", done_cnt - d0, 1);
    check("wr_strobe_count", wr_addr_q.size(), len);
    for (int i = 0; i < len && i < wr_addr_q.size(); i++) begin
      check("wr_addr", wr_addr_q[i], 32'(burst_addr(a, i)));
      check("wr_data", 32'(wr_data_q[i]), 32'(d[i]));
      if (!gaps) check("wr_strobe_cycle", wr_cyc_q[i], first_hs + 1 + i);
    end
    for (int i = 0; i < len; i++) ref_mem[burst_addr(a, i) / 2] = d[i];
  endtask

  // mode 0: rd_ready held high; 1: random rd_ready; 2: stall once first word shows.
  task automatic run_read(input logic [31:0] a, input int len, input int mode);
    logic [15:0] exp[$];
    int acc, done_c, d0;
    bit stalled;
    for (int i = 0; i < len; i++) exp.push_back(ref_mem[burst_addr(a, i) / 2]);
    rd_q.delete(); rd_cyc_q.delete(); rden_cyc_q.delete();
    d0 = done_cnt;
    stalled = 1'b0;
    rd_ready = (mode != 2);
    send_cmd(1'b0, a, len, acc);
    done_c = -1;
    for (int k = 0; k < 400 && done_c < 0; k++) begin
      if (mode == 1) rd_ready = 1'($urandom_range(0, 1));
      else           rd_ready = (mode == 0) || stalled;
      @(negedge clk);
      if (done) begin
        done_c = cyc;
      end else if (mode == 2 && !stalled && rd_valid) begin
        for (int j = 0; j < 10; j++) begin
          check("stall_rd_data", 32'(rd_data), 32'(exp[0]));
          check("stall_no_rd_en", 32'(mem_rd_en), 32'd0);
          tick();
          @(negedge clk);
        end
        stalled = 1'b1;
      end
      if (done_c < 0) tick();
    end
    check("rd_done_seen", 32'(done_c >= 0), 32'd1);
    check("rd_cmd_ready_at_done", 32'(cmd_ready), 32'd0);
    tick();
    @(negedge clk);
    check("rd_cmd_ready_after_done", 32'(cmd_ready), 32'd1);
    tick();
    rd_ready = 1'b1;
    check("rd_done_count", done_cnt - d0, 1);
    check("rd_word_count", rd_q.size(), len);
    check("rd_strobe_count", rden_cyc_q.size(), len);
    for (int i = 0; i < len && i < rd_q.size(); i++)
      check("rd_data", 32'(rd_q[i]), 32'(exp[i]));
    if (rd_cyc_q.size() > 0)
      check("rd_done_cycle", done_c, rd_cyc_q[rd_cyc_q.size() - 1] + 1);
    if (mode == 0) begin
      for (int i = 0; i < len && i < rd_cyc_q.size() && i < rden_cyc_q.size(); i++) begin
        check("rd_latency", rd_cyc_q[i], rden_cyc_q[i] + 2);
        if (i > 0) check("rd_rate", rden_cyc_q[i] - rden_cyc_q[i - 1], 3);
      end
    end
  endtask

  task automatic run_zero(input logic wr);
    int acc, d0;
    wr_addr_q.delete(); rden_cyc_q.delete();
    d0 = done_cnt;
    send_cmd(wr, $urandom, 0, acc);
    @(negedge clk);
    check("zl_done", 32'(done), 32'd1);
    check("zl_done_cycle", cyc, acc + 1);
    check("zl_cmd_ready_low", 32'(cmd_ready), 32'd0);
    tick();
    @(negedge clk);
    check("zl_cmd_ready_back", 32'(cmd_ready), 32'd1);
    check("zl_done_once", 32'(done), 32'd0);
    tick();
    check("zl_no_strobes", wr_addr_q.size() + rden_cyc_q.size(), 0);
    check("zl_done_count", done_cnt - d0, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    check({tag, "_wr_ready"}, 32'(wr_ready), 32'd0);
    check({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_mem_wr_en"}, 32'(mem_wr_en), 32'd0);
    check({tag, "_mem_rd_en"}, 32'(mem_rd_en), 32'd0);
    check({tag, "_rd_data"}, 32'(rd_data), 32'd0);
    check({tag, "_mem_addr"}, mem_addr, 32'd0);
    check({tag, "_mem_data_write"}, 32'(mem_data_write), 32'd0);
  endtask

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  initial begin : main
    int acc, n;
    bit hit;
    logic [31:0] a;
    int len;
    for (int i = 0; i < 65536; i++) ref_mem[i] = '0;

    reset_n = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check_reset_outputs("reset");
    tick();
    reset_n = 1'b1;
    tick();

    run_write(32'h0000_0100, 4, 1'b0, 1'b1);
    run_read(32'h0000_0100, 4, 0);
    run_read(32'h0000_0100, 3, 2);

    run_write(32'h0001_FFFC, 4, 1'b0, 1'b0);
    run_read(32'h0001_FFFC, 4, 1);

    run_zero(1'b1);
    run_zero(1'b0);

    run_write(32'hFFFE_0103, 5, 1'b1, 1'b0);
    run_read(32'h0000_0102, 5, 0);

    for (int t = 0; t < 6; t++) begin
      a = $urandom;
      len = int'($urandom_range(1, 8));
      run_write(a, len, 1'b1, 1'b0);
      run_read(a, len, int'($urandom_range(0, 1)));
    end

    // Reset in the middle of a read burst, while word 2 is outstanding.
    run_write(32'h0000_2000, 5, 1'b0, 1'b0);
    mon_en = 1'b0;
    rd_ready = 1'b1;
    send_cmd(1'b0, 32'h0000_2000, 5, acc);
    n = 0;
    hit = 1'b0;
    for (int k = 0; k < 60 && !hit; k++) begin
      @(negedge clk);
      if (mem_rd_en) n++;
      if (n == 2) hit = 1'b1;
      else tick();
    end
    check("rst_reached_word2", 32'(hit), 32'd1);
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midrst");
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("midrst_no_rd_valid", 32'(rd_valid), 32'd0);
      check("midrst_no_done", 32'(done), 32'd0);
      check("midrst_idle", 32'(cmd_ready), 32'd1);
    end
    tick();
    mon_en = 1'b1;
    run_write(32'h0000_3000, 6, 1'b0, 1'b0);
    run_read(32'h0000_3000, 6, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
